mem_responder: RTL and testbench

- Word-addressed synchronous memory that answers the datapath's memory-access requests: Read/Write strobes plus the MAR address and MDR write data.
- On a read it returns data on Mdatain, which feeds the MDR input mux.
- It models a configurable number of wait states and signals completion with a one-cycle MemDone pulse, so control sequences can stall on it.
- It sits beside DataPath in the CPU top level, replacing bench-driven Mdatain.

---
 rtl/mem_responder_if.sv | 16 +
 rtl/mem_responder.sv | 58 +++++
 tb/tb_mem_responder.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// mem_responder_if: request/response bundle between the datapath (master) and the memory responder (slave).
interface mem_responder_if #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32
);
    logic                  Read;
    logic                  Write;
    logic [ADDR_WIDTH-1:0] Address;
    logic [DATA_WIDTH-1:0] Din;
    logic [DATA_WIDTH-1:0] Mdatain;
    logic                  MemDone;
    logic                  MemErr;
    logic                  Busy;
    modport master (output Read, Write, Address, Din, input Mdatain, MemDone, MemErr, Busy);
    modport slave (input Read, Write, Address, Din, output Mdatain, MemDone, MemErr, Busy);
endinterface

// File: rtl/mem_responder.sv
// mem_responder: word-addressed memory with configurable wait states and one-cycle done/error pulses.
module mem_responder #(
    parameter int ADDR_WIDTH  = 9,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 512,
    parameter int WAIT_STATES = 1
) (
    input logic            clock,
    input logic            clear,
    mem_responder_if.slave bus
);
    localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
    state_t                r_state, w_next;
    logic [3:0]            r_cnt;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr;
    logic [DATA_WIDTH-1:0] r_din, w_din, r_mdatain;
    logic                  r_we, w_we, w_req, w_fire, w_inrange, r_done, r_err;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    // With zero wait states the access happens at the accepting edge, so it uses the live bus values.
    always_comb begin
        w_req     = bus.Read ^ bus.Write;
        w_addr    = (r_state == S_IDLE) ? bus.Address : r_addr;
        w_din     = (r_state == S_IDLE) ? bus.Din : r_din;
        w_we      = (r_state == S_IDLE) ? bus.Write : r_we;
        w_inrange = {1'b0, w_addr} < (ADDR_WIDTH+1)'(DEPTH);
        w_fire    = (r_state == S_IDLE) ? (w_req && WAIT_STATES == 0) : (r_state == S_WAIT && r_cnt == 4'd1);
        w_next    = (r_state == S_IDLE) ? (w_req ? (WAIT_STATES == 0 ? S_DONE : S_WAIT) : S_IDLE)
                  : (r_state == S_WAIT) ? (r_cnt == 4'd1 ? S_DONE : S_WAIT) : S_IDLE;
    end
    always_ff @(posedge clock) begin
        if (clear) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_mdatain <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (r_state == S_WAIT) ? r_cnt - 4'd1 : 4'(WAIT_STATES);
            r_done  <= w_next == S_DONE;
            r_err   <= (r_state == S_IDLE && bus.Read && bus.Write) || (w_fire && !w_inrange);
            if (r_state == S_IDLE && w_req) begin
                r_addr <= bus.Address;
                r_din  <= bus.Din;
                r_we   <= bus.Write;
            end
            if (w_fire && !w_we) r_mdatain <= w_inrange ? r_mem[w_addr[IW-1:0]] : '0;
        end
    end
    always_ff @(posedge clock) begin
        if (!clear && w_fire && w_we && w_inrange) r_mem[w_addr[IW-1:0]] <= w_din;
    end
    assign bus.Mdatain = r_mdatain;
    assign bus.MemDone = r_done;
    assign bus.MemErr  = r_err;
    assign bus.Busy    = r_state != S_IDLE;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: four responders with different wait-state/depth settings checked against a transaction-level model.
module tb_mem_responder;
    localparam int WSL [4] = '{1, 0, 3, 2};
    localparam int DPL [4] = '{512, 512, 512, 256};
    typedef struct packed {logic r; logic w; logic s; logic [8:0] a; logic [31:0] d;} op_t;
    logic        clk;
    logic        clr [4];
    logic        rd [4];
    logic        wr [4];
    logic [8:0]  ad [4];
    logic [31:0] dn [4];
    wire  [31:0] md [4];
    wire         mdone [4];
    wire         merr [4];
    wire         mbusy [4];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] mm [4][512];
    bit          mv [4][512];
    logic [31:0] mq [4];
    bit          mk [4];

    for (genvar g = 0; g < 4; g++) begin : gi
        mem_responder_if #(.ADDR_WIDTH(9), .DATA_WIDTH(32)) b ();
        assign b.Read    = rd[g];
        assign b.Write   = wr[g];
        assign b.Address = ad[g];
        assign b.Din     = dn[g];
        assign md[g]     = b.Mdatain;
        assign mdone[g]  = b.MemDone;
        assign merr[g]   = b.MemErr;
        assign mbusy[g]  = b.Busy;
        mem_responder #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .DEPTH(DPL[g]), .WAIT_STATES(WSL[g])) u (
            .clock(clk), .clear(clr[g]), .bus(b.slave));
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle request issued from a falling edge, then the whole response window is observed.
    task automatic xact(input int i, input op_t op, output int done_at, output int pulses, output int errs,
                        output int err_at, output int busy, output logic [31:0] md_done);
        rd[i] = op.r; wr[i] = op.w; ad[i] = op.a; dn[i] = op.d;
        done_at = 0; pulses = 0; errs = 0; err_at = 0; busy = 0; md_done = 'x;
        @(posedge clk);
        @(negedge clk);
        rd[i] = 1'b0; wr[i] = 1'b0;
        for (int n = 1; n <= WSL[i] + 2; n++) begin
            if (n > 1) @(negedge clk);
            if (op.s) begin ad[i] = 9'($urandom_range(0, 511)); dn[i] = $urandom; end
            if (mdone[i]) begin pulses++; if (done_at == 0) begin done_at = n; md_done = md[i]; end end
            if (merr[i]) begin errs++; if (err_at == 0) err_at = n; end
            if (mbusy[i]) busy++;
        end
        if (done_at == 0) md_done = md[i];
    endtask

    task automatic model(input int i, input op_t op, output int e_d, output int e_p, output int e_e,
                         output int e_ea, output int e_b, output logic [31:0] e_m, output bit e_k);
        bit oob = int'(op.a) >= DPL[i];
        if (op.r == op.w) begin
            e_d = 0; e_p = 0; e_b = 0;
            e_e = op.r ? 1 : 0; e_ea = op.r ? 1 : 0;
        end else begin
            e_d = WSL[i] + 1; e_p = 1; e_b = WSL[i] + 1;
            e_e = oob ? 1 : 0; e_ea = oob ? WSL[i] + 1 : 0;
            if (op.r) begin
                mq[i] = oob ? 32'h0 : mm[i][op.a];
                mk[i] = oob ? 1'b1 : mv[i][op.a];
            end else if (!oob) begin
                mm[i][op.a] = op.d; mv[i][op.a] = 1'b1;
            end
        end
        e_m = mq[i]; e_k = mk[i];
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            clr[i] = 1'b1; rd[i] = 1'b0; wr[i] = 1'b0; ad[i] = '0; dn[i] = '0; mq[i] = '0; mk[i] = 1'b1;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({md[i], mdone[i], merr[i], mbusy[i]} !== 35'h0) begin
                failures++;
                $display("FAIL reset inst%0d: got md=%h done=%b err=%b busy=%b want all zero", i, md[i], mdone[i], merr[i], mbusy[i]);
            end
            clr[i] = 1'b0;
        end
    endtask

    task automatic test_write_read();
        op_t ops [2];
        int g_d, g_p, g_e, g_ea, g_b, e_d, e_p, e_e, e_ea, e_b;
        logic [31:0] g_m, e_m;
        bit e_k;
        ops[0] = '{1'b0, 1'b1, 1'b0, 9'h054, 32'h0000_00B6};
        ops[1] = '{1'b1, 1'b0, 1'b0, 9'h054, 32'h0};
        for (int k = 0; k < 2; k++) begin
            xact(0, ops[k], g_d, g_p, g_e, g_ea, g_b, g_m);
            model(0, ops[k], e_d, e_p, e_e, e_ea, e_b, e_m, e_k);
            checks++;
            if (g_d !== 2 || g_b !== 2 || g_p !== e_p || g_e !== e_e || g_ea !== e_ea) begin
                failures++;
                $display("FAIL wr_rd op%0d timing: got done_at=%0d busy=%0d pulses=%0d errs=%0d want 2 2 %0d %0d", k, g_d, g_b, g_p, g_e, e_p, e_e);
            end
        end
        checks++;
        if (g_m !== 32'h0000_00B6) begin failures++; $display("FAIL wr_rd data: got %h want 000000b6", g_m); end
    endtask

    task automatic test_held_read();
        op_t op = '{1'b0, 1'b1, 1'b0, 9'h001, 32'hDEAD_BEEF};
        int g_d, g_p, g_e, g_ea, g_b, e_d, e_p, e_e, e_ea, e_b;
        logic [31:0] g_m, e_m;
        bit e_k;
        int pulses = 0;
        xact(1, op, g_d, g_p, g_e, g_ea, g_b, g_m);
        model(1, op, e_d, e_p, e_e, e_ea, e_b, e_m, e_k);
        rd[1] = 1'b1; ad[1] = 9'h001;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (mdone[1]) pulses++;
            checks++;
            if (mdone[1] !== 1'(c % 2) || mbusy[1] !== 1'(c % 2) || md[1] !== 32'hDEAD_BEEF) begin
                failures++;
                $display("FAIL held_read cycle%0d: got done=%b busy=%b md=%h want %0d %0d deadbeef", c, mdone[1], mbusy[1], md[1], c % 2, c % 2);
            end
        end
        rd[1] = 1'b0;
        mq[1] = 32'hDEAD_BEEF;
        checks++;
        if (pulses !== 3) begin failures++; $display("FAIL held_read pulses: got %0d want 3", pulses); end
    endtask

    task automatic test_illegal();
        op_t ops [3];
        int g_d, g_p, g_e, g_ea, g_b, e_d, e_p, e_e, e_ea, e_b;
        logic [31:0] g_m, e_m;
        bit e_k;
        ops[0] = '{1'b0, 1'b1, 1'b0, 9'h077, 32'h5555_AAAA};
        ops[1] = '{1'b1, 1'b1, 1'b0, 9'h077, 32'hFFFF_0000};
        ops[2] = '{1'b1, 1'b0, 1'b0, 9'h077, 32'h0};
        for (int k = 0; k < 3; k++) begin
            xact(0, ops[k], g_d, g_p, g_e, g_ea, g_b, g_m);
            model(0, ops[k], e_d, e_p, e_e, e_ea, e_b, e_m, e_k);
            checks++;
            if (g_d !== e_d || g_p !== e_p || g_e !== e_e || g_ea !== e_ea || g_b !== e_b || (e_k && g_m !== e_m)) begin
                failures++;
                $display("FAIL illegal op%0d: got done_at=%0d pulses=%0d errs=%0d err_at=%0d busy=%0d md=%h want %0d %0d %0d %0d %0d %h",
                         k, g_d, g_p, g_e, g_ea, g_b, g_m, e_d, e_p, e_e, e_ea, e_b, e_m);
            end
        end
    endtask

    task automatic test_oob();
        op_t ops [4];
        int g_d, g_p, g_e, g_ea, g_b, e_d, e_p, e_e, e_ea, e_b;
        logic [31:0] g_m, e_m;
        bit e_k;
        ops[0] = '{1'b0, 1'b1, 1'b0, 9'h0F0, 32'h0F0F_0F0F};
        ops[1] = '{1'b1, 1'b0, 1'b0, 9'h1F0, 32'h0};
        ops[2] = '{1'b0, 1'b1, 1'b0, 9'h1F0, 32'hBADB_AD00};
        ops[3] = '{1'b1, 1'b0, 1'b0, 9'h0F0, 32'h0};
        for (int k = 0; k < 4; k++) begin
            xact(3, ops[k], g_d, g_p, g_e, g_ea, g_b, g_m);
            model(3, ops[k], e_d, e_p, e_e, e_ea, e_b, e_m, e_k);
            checks++;
            if (g_d !== e_d || g_p !== e_p || g_e !== e_e || g_ea !== e_ea || g_b !== e_b || (e_k && g_m !== e_m)) begin
                failures++;
                $display("FAIL oob op%0d: got done_at=%0d pulses=%0d errs=%0d err_at=%0d busy=%0d md=%h want %0d %0d %0d %0d %0d %h",
                         k, g_d, g_p, g_e, g_ea, g_b, g_m, e_d, e_p, e_e, e_ea, e_b, e_m);
            end
        end
        checks++;
        if (g_m !== 32'h0F0F_0F0F) begin failures++; $display("FAIL oob alias: got %h want 0f0f0f0f", g_m); end
    endtask

    task automatic test_clear_mid();
        op_t op = '{1'b0, 1'b1, 1'b0, 9'h010, 32'hAAAA_0010};
        int g_d, g_p, g_e, g_ea, g_b, e_d, e_p, e_e, e_ea, e_b;
        logic [31:0] g_m, e_m;
        bit e_k;
        xact(2, op, g_d, g_p, g_e, g_ea, g_b, g_m);
        model(2, op, e_d, e_p, e_e, e_ea, e_b, e_m, e_k);
        wr[2] = 1'b1; ad[2] = 9'h010; dn[2] = 32'h1234_5678;
        @(negedge clk);
        wr[2] = 1'b0;
        @(negedge clk);
        clr[2] = 1'b1;
        @(negedge clk);
        clr[2] = 1'b0;
        mq[2] = '0; mk[2] = 1'b1;
        checks++;
        if (mbusy[2] !== 1'b0 || mdone[2] !== 1'b0 || merr[2] !== 1'b0 || md[2] !== 32'h0) begin
            failures++;
            $display("FAIL clear_mid state: got busy=%b done=%b err=%b md=%h want 0 0 0 0", mbusy[2], mdone[2], merr[2], md[2]);
        end
        op = '{1'b1, 1'b0, 1'b0, 9'h010, 32'h0};
        xact(2, op, g_d, g_p, g_e, g_ea, g_b, g_m);
        model(2, op, e_d, e_p, e_e, e_ea, e_b, e_m, e_k);
        checks++;
        if (g_m !== 32'hAAAA_0010 || g_d !== 4) begin
            failures++;
            $display("FAIL clear_mid reread: got md=%h done_at=%0d want aaaa0010 4", g_m, g_d);
        end
    endtask

    task automatic test_addr_change();
        op_t ops [4];
        int g_d, g_p, g_e, g_ea, g_b, e_d, e_p, e_e, e_ea, e_b;
        logic [31:0] g_m, e_m;
        bit e_k;
        ops[0] = '{1'b0, 1'b1, 1'b0, 9'h020, 32'h2020_2020};
        ops[1] = '{1'b0, 1'b1, 1'b0, 9'h030, 32'h3030_3030};
        ops[2] = '{1'b1, 1'b0, 1'b1, 9'h020, 32'hFFFF_FFFF};
        ops[3] = '{1'b1, 1'b0, 1'b0, 9'h030, 32'h0};
        for (int k = 0; k < 4; k++) begin
            xact(3, ops[k], g_d, g_p, g_e, g_ea, g_b, g_m);
            model(3, ops[k], e_d, e_p, e_e, e_ea, e_b, e_m, e_k);
            checks++;
            if (g_d !== e_d || g_p !== e_p || g_e !== e_e || g_ea !== e_ea || g_b !== e_b || (e_k && g_m !== e_m)) begin
                failures++;
                $display("FAIL addr_change op%0d: got done_at=%0d pulses=%0d errs=%0d err_at=%0d busy=%0d md=%h want %0d %0d %0d %0d %0d %h",
                         k, g_d, g_p, g_e, g_ea, g_b, g_m, e_d, e_p, e_e, e_ea, e_b, e_m);
            end
        end
    endtask

    task automatic test_random();
        op_t op;
        int g_d, g_p, g_e, g_ea, g_b, e_d, e_p, e_e, e_ea, e_b, kind;
        logic [31:0] g_m, e_m;
        bit e_k;
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 24; k++) begin
                kind = int'($urandom_range(0, 9));
                op.r = kind < 5 || kind == 9;
                op.w = kind >= 5;
                op.s = 1'($urandom_range(0, 1));
                op.a = {1'($urandom_range(0, 1)), 4'h0, 4'($urandom_range(0, 15))};
                op.d = $urandom;
                xact(i, op, g_d, g_p, g_e, g_ea, g_b, g_m);
                model(i, op, e_d, e_p, e_e, e_ea, e_b, e_m, e_k);
                checks++;
                if (g_d !== e_d || g_p !== e_p || g_e !== e_e || g_ea !== e_ea || g_b !== e_b || (e_k && g_m !== e_m)) begin
                    failures++;
                    $display("FAIL random inst%0d op%0d r=%b w=%b a=%h: got done_at=%0d pulses=%0d errs=%0d err_at=%0d busy=%0d md=%h want %0d %0d %0d %0d %0d %h",
                             i, k, op.r, op.w, op.a, g_d, g_p, g_e, g_ea, g_b, g_m, e_d, e_p, e_e, e_ea, e_b, e_m);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_held_read();
        test_illegal();
        test_oob();
        test_clear_mid();
        test_addr_change();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
